// File: rtl/conv_window_sequencer_pkg.sv
// Package conv_pkg: shared definitions for the convolution window sequencer.
//   conv_state_t  - sequencer FSM state encoding
//   ALU_OP_*      - ALUControl codes driven on alu_ctrl
//   LANE_*        - byte lane of each window pixel inside the packed ALU A operand
//   set_lane      - replaces one byte lane of a packed 32-bit window word
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_EXEC,
    S_OUT,
    S_DONE
  } conv_state_t;

  localparam logic [2:0] ALU_OP_CONV = 3'b111;
  localparam logic [2:0] ALU_OP_ADD  = 3'b000;

  // Lane index equals the fetch index k: k[0] selects column, k[1] selects row.
  localparam logic [1:0] LANE_P00 = 2'd0;  // p(r,c)
  localparam logic [1:0] LANE_P01 = 2'd1;  // p(r,c+1)
  localparam logic [1:0] LANE_P10 = 2'd2;  // p(r+1,c)
  localparam logic [1:0] LANE_P11 = 2'd3;  // p(r+1,c+1)

  function automatic logic [31:0] set_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  value);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = value;
    return res;
  endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Result stream interface of the convolution window sequencer.
//   out_valid  - result available (master)
//   out_ready  - downstream accept (slave)
//   out_data   - window result
//   out_row    - window row r
//   out_col    - window column c
interface conv_window_sequencer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_row;
  logic [7:0]  out_col;

  modport master (output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/conv_window_sequencer_addr_gen.sv
// conv_window_addr_gen: window position counters and image read address.
//   clk, rst   - clock, asynchronous active-low reset
//   clear      - restart at window (0,0)
//   advance    - step to the next window in raster order
//   k          - fetch index within the 2x2 window
//   row, col   - current window origin
//   last       - current window is (IMG_H-2, IMG_W-2)
//   raddr      - BASE_ADDR + (row+k[1])*IMG_W + col + k[0]
module conv_window_addr_gen #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        k,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic              last,
  output logic [ADDR_W-1:0] raddr
);

  localparam logic [7:0] COL_LAST = 8'(IMG_W - 2);
  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 2);

  logic [ADDR_W-1:0] pix_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    pix_row = ADDR_W'(row) + ADDR_W'(k[1]);
    raddr   = ADDR_W'(BASE_ADDR) + pix_row * ADDR_W'(IMG_W)
            + ADDR_W'(col) + ADDR_W'(k[0]);
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: issue side of the ALU convolution op. Walks the image
// with a 2x2 window, packs each window into alu_a, presents the latched kernel
// on alu_b, captures alu_result and streams it out with its (row,col).
//   clk, rst            - clock, asynchronous active-low reset
//   start, kernel       - begin a pass (IDLE only), 4 x int8 weights
//   busy, done          - pass in progress, one-cycle completion pulse
//   mem_ren/raddr/rdata - image byte read port, 1-cycle read latency
//   alu_a/b/ctrl/result - ALU operand, op code and combinational result
//   out                 - result stream (conv_window_sequencer_if.master)
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             kernel,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ren,
  output logic [ADDR_W-1:0]       mem_raddr,
  input  logic [7:0]              mem_rdata,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [31:0]             alu_result,
  conv_window_sequencer_if.master out
);

  conv_state_t       state;
  logic [1:0]        k;
  logic [31:0]       window;
  logic [31:0]       kernel_q;
  logic [31:0]       out_data_q;
  logic [7:0]        out_row_q;
  logic [7:0]        out_col_q;
  logic              out_valid_q;
  logic [31:0]       captured;
  logic [7:0]        row;
  logic [7:0]        col;
  logic              last;
  logic [ADDR_W-1:0] raddr;
  logic              clear;
  logic              advance;

  assign clear   = (state == S_IDLE) && start;
  // The last window is not advanced past, so r/c stay inside the image.
  assign advance = (state == S_OUT) && out.out_ready && !last;

  conv_window_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .k       (k),
    .row     (row),
    .col     (col),
    .last    (last),
    .raddr   (raddr)
  );

`ifdef CONV_RELU_EN
  assign captured = alu_result[31] ? '0 : alu_result;
`else
  assign captured = alu_result;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      k           <= '0;
      window      <= '0;
      kernel_q    <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_ren     <= 1'b0;
      alu_ctrl    <= ALU_OP_ADD;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kernel_q <= kernel;
            busy     <= 1'b1;
            k        <= '0;
            mem_ren  <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data returns one cycle late, so fetch k lands byte k-1.
          if (k != 2'd0) window <= set_lane(window, k - 2'd1, mem_rdata);
          if (k == 2'd3) begin
            mem_ren <= 1'b0;
            state   <= S_CAPTURE;
          end else begin
            k <= k + 2'd1;
          end
        end
        S_CAPTURE: begin
          window   <= set_lane(window, LANE_P11, mem_rdata);
          alu_ctrl <= ALU_OP_CONV;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          out_data_q  <= captured;
          out_row_q   <= row;
          out_col_q   <= col;
          alu_ctrl    <= ALU_OP_ADD;
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (out.out_ready) begin
            out_valid_q <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              k       <= '0;
              mem_ren <= 1'b1;
              state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_raddr     = mem_ren ? raddr : '0;
  assign alu_a         = window;
  assign alu_b         = kernel_q;
  assign out.out_valid = out_valid_q;
  assign out.out_data  = out_data_q;
  assign out.out_row   = out_row_q;
  assign out.out_col   = out_col_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: a 3x3 instance for the functional
// passes and an 8x8 instance at BASE_ADDR=16 for address ordering.
module tb_conv_window_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DUT 0: 3x3 image ----------------
  logic        start0 = 1'b0;
  logic [31:0] kernel0 = '0;
  logic        busy0, done0, mem_ren0;
  logic [9:0]  mem_raddr0;
  logic [7:0]  mem_rdata0 = '0;
  logic [31:0] alu_a0, alu_b0, alu_result0;
  logic [2:0]  alu_ctrl0;
  logic [7:0]  img0 [0:1023];
  conv_window_sequencer_if if0 ();

  conv_window_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(10), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .kernel(kernel0), .busy(busy0), .done(done0),
    .mem_ren(mem_ren0), .mem_raddr(mem_raddr0), .mem_rdata(mem_rdata0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctrl(alu_ctrl0), .alu_result(alu_result0),
    .out(if0)
  );

  // ---------------- DUT 1: 8x8 image at byte 16 ----------------
  logic        start1 = 1'b0;
  logic        busy1, done1, mem_ren1;
  logic [9:0]  mem_raddr1;
  logic [7:0]  mem_rdata1 = '0;
  logic [31:0] alu_a1, alu_b1, alu_result1;
  logic [2:0]  alu_ctrl1;
  logic [7:0]  img1 [0:1023];
  conv_window_sequencer_if if1 ();

  conv_window_sequencer #(.IMG_W(8), .IMG_H(8), .ADDR_W(10), .BASE_ADDR(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .kernel(32'h01010101), .busy(busy1), .done(done1),
    .mem_ren(mem_ren1), .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1), .alu_result(alu_result1),
    .out(if1)
  );

  // ALU model: signed sum of uint8 pixel x int8 weight over 4 lanes.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  assign alu_result0 = alu_model(alu_a0, alu_b0);
  assign alu_result1 = alu_model(alu_a1, alu_b1);

  always @(posedge clk) begin
    if (mem_ren0) mem_rdata0 <= img0[mem_raddr0];
    if (mem_ren1) mem_rdata1 <= img1[mem_raddr1];
  end

  // ---------------- monitors (sample on negedge) ----------------
  int          busy_cyc, done_cyc, ren_cyc, exec_cyc, hold_err, n_out;
  logic [31:0] od   [0:63];
  logic [7:0]  orow [0:63];
  logic [7:0]  ocol [0:63];
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [47:0] prev_pay = '0;

  int          n_out1, ren1_cyc, n_addr1;
  logic [9:0]  addr_log [0:255];

  always @(negedge clk) begin
    if (busy0) busy_cyc++;
    if (done0) done_cyc++;
    if (mem_ren0) ren_cyc++;
    if (alu_ctrl0 == 3'b111) exec_cyc++;
    if (rst && prev_v && !prev_hs &&
        (!if0.out_valid || {if0.out_data, if0.out_row, if0.out_col} != prev_pay))
      hold_err++;
    if (if0.out_valid && if0.out_ready) begin
      if (n_out < 64) begin
        od[n_out]   = if0.out_data;
        orow[n_out] = if0.out_row;
        ocol[n_out] = if0.out_col;
      end
      n_out++;
    end
    prev_v   = if0.out_valid;
    prev_hs  = if0.out_valid && if0.out_ready;
    prev_pay = {if0.out_data, if0.out_row, if0.out_col};

    if (mem_ren1) begin
      if (n_addr1 < 256) addr_log[n_addr1] = mem_raddr1;
      n_addr1++;
      ren1_cyc++;
    end
    if (if1.out_valid && if1.out_ready) n_out1++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    busy_cyc = 0; done_cyc = 0; ren_cyc = 0; exec_cyc = 0; hold_err = 0; n_out = 0;
  endtask

  task automatic pulse_start0(input logic [31:0] kv);
    kernel0 = kv;
    start0  = 1'b1;
    @(posedge clk); #1;
    start0  = 1'b0;
  endtask

  task automatic wait_done0(input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (done0) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy0),         32'd0);
    check({tag, "_done"},      32'(done0),         32'd0);
    check({tag, "_mem_ren"},   32'(mem_ren0),      32'd0);
    check({tag, "_mem_raddr"}, 32'(mem_raddr0),    32'd0);
    check({tag, "_alu_a"},     alu_a0,             32'd0);
    check({tag, "_alu_b"},     alu_b0,             32'd0);
    check({tag, "_alu_ctrl"},  32'(alu_ctrl0),     32'd0);
    check({tag, "_out_valid"}, 32'(if0.out_valid), 32'd0);
    check({tag, "_out_data"},  if0.out_data,       32'd0);
    check({tag, "_out_row"},   32'(if0.out_row),   32'd0);
    check({tag, "_out_col"},   32'(if0.out_col),   32'd0);
  endtask

  task automatic check_windows(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "_count"}, 32'(n_out), 32'd4);
    check({tag, "_w0"}, od[0], e0);
    check({tag, "_w1"}, od[1], e1);
    check({tag, "_w2"}, od[2], e2);
    check({tag, "_w3"}, od[3], e3);
    check({tag, "_rc0"}, {orow[0], ocol[0]}, 32'h0000);
    check({tag, "_rc1"}, {orow[1], ocol[1]}, 32'h0001);
    check({tag, "_rc2"}, {orow[2], ocol[2]}, 32'h0100);
    check({tag, "_rc3"}, {orow[3], ocol[3]}, 32'h0101);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    for (int i = 0; i < 1024; i++) begin
      img0[i] = (i < 9) ? 8'(i + 1) : 8'd0;
      img1[i] = 8'(i);
    end
    n_out1 = 0; ren1_cyc = 0; n_addr1 = 0;
    clr_mon();
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Pass A: kernel all ones, no backpressure
    clr_mon();
    pulse_start0(32'h01010101);
    wait_done0(200, "passA_done_timeout");
    check_windows("passA", 32'd12, 32'd16, 32'd24, 32'd28);
    check("passA_busy_cycles", 32'(busy_cyc), 32'd28);
    check("passA_done_cycles", 32'(done_cyc), 32'd1);
    check("passA_ren_cycles",  32'(ren_cyc),  32'd16);
    check("passA_exec_cycles", 32'(exec_cyc), 32'd4);
    check("passA_idle_busy",   32'(busy0),    32'd0);

    // Pass B: out_ready low for 5 cycles on the second window
    clr_mon();
    pulse_start0(32'h01010101);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (if0.out_valid && n_out == 1) begin ok = 1'b1; break; end
    end
    check("passB_w1_timeout", 32'(ok), 32'd1);
    if0.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("passB_stall_valid", 32'(if0.out_valid), 32'd1);
    check("passB_stall_data",  if0.out_data,       32'd16);
    check("passB_stall_ren",   32'(mem_ren0),      32'd0);
    repeat (2) @(posedge clk);
    #1;
    if0.out_ready = 1'b1;
    wait_done0(200, "passB_done_timeout");
    check_windows("passB", 32'd12, 32'd16, 32'd24, 32'd28);
    check("passB_busy_cycles", 32'(busy_cyc), 32'd33);
    check("passB_ren_cycles",  32'(ren_cyc),  32'd16);
    check("passB_hold_err",    32'(hold_err), 32'd0);

    // Negative kernel: only p(r+1,c+1) weighted by -1
    clr_mon();
    pulse_start0(32'hFF000000);
    wait_done0(200, "neg_done_timeout");
    check("neg_alu_b", alu_b0, 32'hFF000000);
`ifdef CONV_RELU_EN
    check_windows("neg", 32'd0, 32'd0, 32'd0, 32'd0);
`else
    check_windows("neg", 32'hFFFFFFFB, 32'hFFFFFFFA, 32'hFFFFFFF8, 32'hFFFFFFF7);
`endif

    // Reset during FETCH of window 1, then restart
    clr_mon();
    pulse_start0(32'h01010101);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_ren0 && n_out == 1) begin ok = 1'b1; break; end
    end
    check("rstmid_fetch_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clr_mon();
    pulse_start0(32'h01010101);
    wait_done0(200, "restart_done_timeout");
    check_windows("restart", 32'd12, 32'd16, 32'd24, 32'd28);

    // start pulses while busy and in DONE are ignored
    clr_mon();
    pulse_start0(32'h01010101);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 3 || i == 12 || i == 20) begin
        start0 = 1'b1; kernel0 = 32'h02020202;
      end else begin
        start0 = 1'b0;
      end
      if (done0) begin ok = 1'b1; break; end
    end
    check("ign_done_timeout", 32'(ok), 32'd1);
    start0 = 1'b1; kernel0 = 32'h03030303;
    @(posedge clk); #1;
    start0 = 1'b0; kernel0 = '0;
    repeat (4) @(posedge clk);
    #1;
    check_windows("ign", 32'd12, 32'd16, 32'd24, 32'd28);
    check("ign_alu_b",    alu_b0,           32'h01010101);
    check("ign_busy",     32'(busy0),       32'd0);
    check("ign_ren",      32'(ren_cyc),     32'd16);
    check("ign_done_cyc", 32'(done_cyc),    32'd1);

    // Address order on the 8x8 instance, window (2,3) is index 17
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (done1) begin ok = 1'b1; break; end
    end
    check("addr_done_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    check("addr_k0", 32'(addr_log[68]), 32'd35);
    check("addr_k1", 32'(addr_log[69]), 32'd36);
    check("addr_k2", 32'(addr_log[70]), 32'd43);
    check("addr_k3", 32'(addr_log[71]), 32'd44);
    check("addr_first", 32'(addr_log[0]), 32'd16);
    check("addr_windows", 32'(n_out1), 32'd49);
    check("addr_ren_cycles", 32'(ren1_cyc), 32'd196);
    check("addr_last_rc", {if1.out_row, if1.out_col}, 32'h0606);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
